// File: rtl/hv_mon_pkg.sv
// Shared types and constants for the HV hold-enable pulse monitor.
package hv_mon_pkg;

    // Width of the sub-second remainder counter; holds 0..CLK_HZ-1 for CLK_HZ up to 2^27.
    localparam int SUB_W = 27;

    // Seconds counter ceiling; the count sticks here instead of wrapping.
    localparam logic [7:0] SEC_MAX = 8'd255;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        WAIT_LOW,   // wait for the line to be seen low before arming
        IDLE,       // armed, waiting for a rising edge
        MEAS,       // pulse in progress, counting high samples
        REPORT      // pulse ended, publish result and check short
    } state_t;

endpackage

// File: rtl/hv_hold_monitor_sec_tick_counter.sv
// Seconds/remainder counter for the pulse-width measurement.
// A clear loads a count of one because the cycle that starts a pulse is itself a high sample.
module sec_tick_counter
    import hv_mon_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic             clk_hvm,
    input  logic             rst_hvm,
    input  logic             clear,
    input  logic             enable,
    output logic [SUB_W-1:0] sub,
    output logic [7:0]       sec,
    output logic             sat
);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_HZ - 1);

    // Count high samples: remainder wraps at CLK_HZ and carries into a saturating seconds count.
    always_ff @(posedge clk_hvm or posedge rst_hvm) begin
        if (rst_hvm) begin
            sub <= '0;
            sec <= '0;
        end else if (clear) begin
            sub <= SUB_W'(1);
            sec <= '0;
        end else if (enable) begin
            if (sub == SUB_LAST) begin
                sub <= '0;
                if (sec != SEC_MAX) begin
                    sec <= sec + 8'd1;
                end
            end else begin
                sub <= sub + SUB_W'(1);
            end
        end
    end

    // Seconds have reached the ceiling; the remainder keeps running underneath.
    assign sat = (sec == SEC_MAX);

endmodule

// File: rtl/hv_hold_monitor.sv
// Receive-side checker for the HV hold-enable line: measures each high pulse
// in seconds plus remainder cycles and flags pulses that are short, long or
// saturated against the commanded hold time. TOL_CYC must be below CLK_HZ and
// MIN_CYC must not exceed CLK_HZ.
module hv_hold_monitor
    import hv_mon_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TOL_CYC = 1_000,
    parameter int MIN_CYC = 4
) (
    input  logic             clk_hvm,
    input  logic             rst_hvm,
    input  logic             hv_in,
    input  logic [7:0]       expected,
    input  logic             clr_flt,
    output logic             hv_active,
    output logic             meas_valid,
    output logic [7:0]       meas_sec,
    output logic [SUB_W-1:0] meas_sub,
    output logic             hv_short,
    output logic             hv_long,
    output logic             hv_sat,
    output logic [7:0]       glitch_cnt
);

    // Remainder thresholds, pre-sized to the counter width.
    localparam logic [SUB_W-1:0] TOL_SUB   = SUB_W'(TOL_CYC);
    localparam logic [SUB_W-1:0] SHORT_SUB = SUB_W'(CLK_HZ - TOL_CYC);
    localparam logic [SUB_W-1:0] MIN_SUB   = SUB_W'(MIN_CYC);

    logic             sync_1;
    logic             hs;
    logic [1:0]       sync_fill;
    logic             sync_ok;
    state_t           state;
    logic [7:0]       exp_q;
    logic [SUB_W-1:0] sub;
    logic [7:0]       sec;
    logic             sat;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             long_hit;
    logic             short_hit;
    logic             is_glitch;

    // Two-flop synchronizer for the asynchronous line, plus a fill marker that
    // says when hs reflects the real line rather than the reset value.
    always_ff @(posedge clk_hvm or posedge rst_hvm) begin
        if (rst_hvm) begin
            sync_1    <= 1'b0;
            hs        <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the old value of
            // the previous one, which is what gives a true two-stage pipeline.
            sync_1    <= hv_in;
            hs        <= sync_1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign sync_ok = sync_fill[1];

    // In IDLE the line is known to have been low, so a high sample is a rising edge;
    // in MEAS a low sample is the falling edge.
    assign cnt_clear  = (state == IDLE) && hs;
    assign cnt_enable = (state == MEAS) && hs;

    sec_tick_counter #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_counter (
        .clk_hvm (clk_hvm),
        .rst_hvm (rst_hvm),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .sub     (sub),
        .sec     (sec),
        .sat     (sat)
    );

    // Long: this high sample takes the count from nominal+TOL to nominal+TOL+1.
    // Firing on that exact sample keeps a later clear effective while the line stays high.
    assign long_hit = (exp_q != 8'd0) && hs && (sec == exp_q) && (sub == TOL_SUB);

    // Short: count below nominal-TOL, derived from sec/sub so no multiplier is needed.
    assign short_hit = (exp_q != 8'd0) &&
                       ((sec < (exp_q - 8'd1)) ||
                        ((sec == (exp_q - 8'd1)) && (sub < SHORT_SUB)));

    // Glitch: fewer than MIN_CYC high samples in the whole pulse.
    assign is_glitch = (sec == 8'd0) && (sub < MIN_SUB);

    // Measurement FSM with registered status outputs and sticky fault flags.
    always_ff @(posedge clk_hvm or posedge rst_hvm) begin
        if (rst_hvm) begin
            // NOTE: every register here is a plain flop with no storage array behind
            // it, so all of them get an explicit reset value.
            state      <= WAIT_LOW;
            exp_q      <= '0;
            hv_active  <= 1'b0;
            meas_valid <= 1'b0;
            meas_sec   <= '0;
            meas_sub   <= '0;
            hv_short   <= 1'b0;
            hv_long    <= 1'b0;
            hv_sat     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            meas_valid <= 1'b0;

            // NOTE: the clear is written before the case so that any flag set below,
            // being the later non-blocking assignment, wins in the same cycle.
            if (clr_flt) begin
                hv_short <= 1'b0;
                hv_long  <= 1'b0;
                hv_sat   <= 1'b0;
            end

            case (state)
                WAIT_LOW: begin
                    if (sync_ok && !hs) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (hs) begin
                        state     <= MEAS;
                        exp_q     <= expected;
                        hv_active <= 1'b1;
                    end
                end

                MEAS: begin
                    if (sat) begin
                        hv_sat <= 1'b1;
                    end
                    if (long_hit) begin
                        hv_long <= 1'b1;
                    end
                    if (!hs) begin
                        state     <= REPORT;
                        hv_active <= 1'b0;
                    end
                end

                REPORT: begin
                    state <= IDLE;
                    if (is_glitch) begin
                        glitch_cnt <= glitch_cnt + 8'd1;
                    end else begin
                        meas_sec   <= sec;
                        meas_sub   <= sub;
                        meas_valid <= 1'b1;
                        if (short_hit) begin
                            hv_short <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= WAIT_LOW;
                end
            endcase
        end
    end

endmodule
